calendar_date_counter: RTL and testbench
========================================

Name: calendar_date_counter

Overview:
- Sequential successor to the combinational day-of-year calculator.
- Holds a running calendar date (day, month, year). Advances it by one day per `tick_i` pulse.
- Keeps day-of-year and the leap-year flag up to date incrementally, and accepts validated date loads over a valid/ready handshake.
- Sits beside timekeeping logic in the game/clock subsystem, fed by a once-per-day strobe.

Parameters:
- YEAR_W, 11, width of the year field; year range is 0 to 2**YEAR_W-1.
- RST_YEAR, 2000, year applied on reset; must be less than 2**YEAR_W.
- RST_DOW, 6, day-of-week of RST_YEAR-01-01 (0=Sunday); used only with DAY_OF_WEEK_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tick_i  in  1  advance date by one day; single-cycle pulse.
- load_valid_i  in  1  load request.
- load_ready_o  out  1  block can accept a load.
- load_day_i  in  6  day of month to load (1-31).
- load_month_i  in  4  month to load (1-12).
- load_year_i  in  YEAR_W  year to load.
- load_err_o  out  1  one-cycle pulse: rejected load.
- day_o  out  6  current day of month.
- month_o  out  4  current month.
- year_o  out  YEAR_W  current year.
- day_of_year_o  out  9  current day of year, 1-366.
- leap_o  out  1  current year is a leap year.
- year_wrap_o  out  1  one-cycle pulse when the year rolls from max to 0.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - day_o=1, month_o=1, year_o=RST_YEAR, day_of_year_o=1.
  - leap_o = leap(RST_YEAR).
  - load_ready_o=1, load_err_o=0, year_wrap_o=0.
  - FSM enters IDLE.
- Leap rule: leap = (y%400==0) || (y%4==0 && y%100!=0). Year 0 is a leap year.
- Month length: 31/28/31/30/31/30/31/31/30/31/30/31. February is 29 when leap.
- FSM states: IDLE, CHECK, COMMIT.
- IDLE:
  - load_ready_o=1.
  - load_valid_i=1: capture the load fields into shadow registers, go to CHECK. load_ready_o drops the next cycle.
  - tick_i=1 with no load: advance the date (see below); stay in IDLE.
  - tick_i and load_valid_i in the same cycle: the load wins and the tick is dropped.
- CHECK (1 cycle):
  - Compute leap for the shadow year.
  - Invalid load: month 0 or >12, day 0, or day greater than that month's length.
    - Pulse load_err_o for 1 cycle; current date unchanged; return to IDLE.
  - Valid load: compute shadow day_of_year = cumulative month offset + day + (leap && month>2); go to COMMIT.
- COMMIT (1 cycle):
  - Copy the shadow registers to the outputs; go to IDLE.
  - Total load latency: valid handshake to updated outputs = 3 clk edges.
- Ticks arriving in CHECK or COMMIT are ignored, not queued.
- Advance rules (outputs update on the edge after tick_i):
  - day < month length: day+1, day_of_year+1.
  - End of month (not December): day=1, month+1, day_of_year+1.
  - Dec 31: day=1, month=1, day_of_year=1, year+1, leap recomputed for the new year.
  - Year at 2**YEAR_W-1 on Dec 31: year wraps to 0, leap=1, year_wrap_o pulses 1 cycle.
- day_of_year_o is maintained incrementally. It must never exceed 365 in non-leap years or 366 in leap years.
- Reset asserted mid-load aborts the load: the shadow registers are discarded and reset values apply immediately (asynchronous).
- load_err_o and year_wrap_o are registered and never asserted in the same cycle.

Optional Feature:
- Macro: DAY_OF_WEEK_EN.
- Defined:
  - Adds input load_dow_i [2:0], captured with the load fields.
  - Adds output dow_o [2:0] (0=Sunday..6=Saturday), reset to RST_DOW.
  - dow_o increments modulo 7 on every accepted tick and is replaced by load_dow_i at COMMIT.
  - load_dow_i > 6 counts as an invalid load and pulses load_err_o.
- Undefined: neither port exists; no day-of-week logic.

Test Plan:
- Reset, then one tick -> 2000-01-02, day_of_year_o=2, leap_o=1 (dow_o=0 when DAY_OF_WEEK_EN is defined).
- Load 2000-02-28, then two ticks -> 02-29 (doy 60), then 03-01 (doy 61).
- Load 1900-02-28, then one tick -> 1900-03-01, doy 60, leap_o=0.
- Load 2023-12-31 (doy 365), then one tick -> 2024-01-01, doy 1, leap_o=1.
- Load 2023-02-29 -> load_err_o pulses 1 cycle, date unchanged. Load month 13 -> same.
- Load 2047-12-31, then one tick -> year_o=0, doy 1, leap_o=1, year_wrap_o pulses. Separately, tick during CHECK is ignored, and tick+load in the same cycle -> load applied, tick dropped.

Source files
------------

// File: rtl/calendar_date_counter.sv
// -----------------------------------------------------------------------------
// calendar_date_counter
//
// Running calendar date (day, month, year) advanced one day per tick_i pulse.
// Day-of-year and the leap flag are maintained incrementally alongside the date.
// New dates are loaded over a valid/ready handshake. Each load is captured into
// shadow registers, validated for one cycle (CHECK) and then committed (COMMIT).
// An invalid load pulses load_err_o and leaves the current date untouched.
//
// Optional feature macro: DAY_OF_WEEK_EN
//   When defined, this adds load_dow_i/dow_o. dow_o is the day of week
//   (0=Sunday). It advances on every accepted tick and is replaced on commit.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   tick_i         advance the date by one day (single-cycle pulse)
//   load_valid_i   load request; accepted while load_ready_o is high
//   load_ready_o   high in IDLE only
//   load_day_i     day of month to load (1-31)
//   load_month_i   month to load (1-12)
//   load_year_i    year to load
//   load_dow_i     day of week to load (DAY_OF_WEEK_EN only)
//   load_err_o     one-cycle pulse when a load is rejected
//   day_o          current day of month
//   month_o        current month
//   year_o         current year
//   day_of_year_o  current day of year (1-366)
//   leap_o         current year is a leap year
//   dow_o          current day of week (DAY_OF_WEEK_EN only)
//   year_wrap_o    one-cycle pulse when the year rolls over from max to 0
// -----------------------------------------------------------------------------
module calendar_date_counter #(
    parameter int unsigned YEAR_W   = 11,
    parameter int unsigned RST_YEAR = 2000,
    parameter int unsigned RST_DOW  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_i,
    input  logic              load_valid_i,
    output logic              load_ready_o,
    input  logic [5:0]        load_day_i,
    input  logic [3:0]        load_month_i,
    input  logic [YEAR_W-1:0] load_year_i,
    output logic              load_err_o,
    output logic [5:0]        day_o,
    output logic [3:0]        month_o,
    output logic [YEAR_W-1:0] year_o,
    output logic [8:0]        day_of_year_o,
    output logic              leap_o,
`ifdef DAY_OF_WEEK_EN
    input  logic [2:0]        load_dow_i,
    output logic [2:0]        dow_o,
`endif
    output logic              year_wrap_o
);

    // Catch parameter sets that cannot be represented, at elaboration time.
    if (((RST_YEAR >> YEAR_W) != 0) || (RST_DOW > 6)) begin : g_param_check
        $error("calendar_date_counter: RST_YEAR or RST_DOW out of range");
    end

    localparam logic [YEAR_W-1:0] RstYearV = YEAR_W'(RST_YEAR);
    localparam logic [YEAR_W-1:0] YearOne  = YEAR_W'(1);
    localparam logic              RstLeap  = ((RST_YEAR % 400) == 0) ||
                                             (((RST_YEAR % 4) == 0) && ((RST_YEAR % 100) != 0));

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StCommit
    } state_e;

    // -------------------------------------------------------------------------
    // Calendar helper functions
    // -------------------------------------------------------------------------
    function automatic logic f_leap(input logic [YEAR_W-1:0] y);
        logic [31:0] v;
        v = 32'(y);
        return ((v % 32'd400) == 32'd0) ||
               ((v[1:0] == 2'b00) && ((v % 32'd100) != 32'd0));
    endfunction

    // Returns 0 for an out-of-range month so such a load can never validate.
    function automatic logic [5:0] f_month_len(input logic [3:0] m, input logic lp);
        logic [5:0] len;
        case (m)
            4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: len = 6'd31;
            4'd4, 4'd6, 4'd9, 4'd11:                   len = 6'd30;
            4'd2:                                      len = lp ? 6'd29 : 6'd28;
            default:                                   len = 6'd0;
        endcase
        return len;
    endfunction

    // Days before the first of month m in a non-leap year.
    function automatic logic [8:0] f_month_offset(input logic [3:0] m);
        logic [8:0] off;
        case (m)
            4'd1:    off = 9'd0;
            4'd2:    off = 9'd31;
            4'd3:    off = 9'd59;
            4'd4:    off = 9'd90;
            4'd5:    off = 9'd120;
            4'd6:    off = 9'd151;
            4'd7:    off = 9'd181;
            4'd8:    off = 9'd212;
            4'd9:    off = 9'd243;
            4'd10:   off = 9'd273;
            4'd11:   off = 9'd304;
            4'd12:   off = 9'd334;
            default: off = 9'd0;
        endcase
        return off;
    endfunction

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_e            r_state;
    logic [5:0]        r_day;
    logic [3:0]        r_month;
    logic [YEAR_W-1:0] r_year;
    logic [8:0]        r_doy;
    logic              r_leap;
    logic              r_err;
    logic              r_wrap;

    // Shadow copy of a load in flight.
    logic [5:0]        r_ld_day;
    logic [3:0]        r_ld_month;
    logic [YEAR_W-1:0] r_ld_year;
    logic [8:0]        r_ld_doy;
    logic              r_ld_leap;

    state_e            w_state_d;
    logic [5:0]        w_day_d;
    logic [3:0]        w_month_d;
    logic [YEAR_W-1:0] w_year_d;
    logic [8:0]        w_doy_d;
    logic              w_leap_d;
    logic              w_err_d;
    logic              w_wrap_d;
    logic [5:0]        w_ld_day_d;
    logic [3:0]        w_ld_month_d;
    logic [YEAR_W-1:0] w_ld_year_d;
    logic [8:0]        w_ld_doy_d;
    logic              w_ld_leap_d;

`ifdef DAY_OF_WEEK_EN
    localparam logic [2:0] RstDowV = 3'(RST_DOW);
    logic [2:0] r_dow;
    logic [2:0] r_ld_dow;
    logic [2:0] w_dow_d;
    logic [2:0] w_ld_dow_d;
    logic       w_ld_dow_ok;
    assign w_ld_dow_ok = (r_ld_dow <= 3'd6);
`else
    logic       w_ld_dow_ok;
    assign w_ld_dow_ok = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic [5:0] w_cur_mlen;
    logic       w_ld_leap;
    logic [5:0] w_ld_mlen;
    logic       w_ld_ok;
    logic [8:0] w_ld_doy;

    assign w_cur_mlen = f_month_len(r_month, r_leap);
    assign w_ld_leap  = f_leap(r_ld_year);
    assign w_ld_mlen  = f_month_len(r_ld_month, w_ld_leap);
    assign w_ld_ok    = (r_ld_month != 4'd0) && (r_ld_month <= 4'd12) &&
                        (r_ld_day != 6'd0) && (r_ld_day <= w_ld_mlen) && w_ld_dow_ok;
    // The February 29th correction applies only to dates after February.
    assign w_ld_doy   = f_month_offset(r_ld_month) + 9'(r_ld_day) +
                        9'(w_ld_leap && (r_ld_month > 4'd2));

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_d    = r_state;
        w_day_d      = r_day;
        w_month_d    = r_month;
        w_year_d     = r_year;
        w_doy_d      = r_doy;
        w_leap_d     = r_leap;
        w_err_d      = 1'b0;
        w_wrap_d     = 1'b0;
        w_ld_day_d   = r_ld_day;
        w_ld_month_d = r_ld_month;
        w_ld_year_d  = r_ld_year;
        w_ld_doy_d   = r_ld_doy;
        w_ld_leap_d  = r_ld_leap;
`ifdef DAY_OF_WEEK_EN
        w_dow_d      = r_dow;
        w_ld_dow_d   = r_ld_dow;
`endif

        unique case (r_state)
            StIdle: begin
                if (load_valid_i) begin
                    // A load takes priority; a coincident tick is dropped.
                    w_ld_day_d   = load_day_i;
                    w_ld_month_d = load_month_i;
                    w_ld_year_d  = load_year_i;
`ifdef DAY_OF_WEEK_EN
                    w_ld_dow_d   = load_dow_i;
`endif
                    w_state_d    = StCheck;
                end else if (tick_i) begin
`ifdef DAY_OF_WEEK_EN
                    w_dow_d = (r_dow >= 3'd6) ? 3'd0 : r_dow + 3'd1;
`endif
                    if (r_day < w_cur_mlen) begin
                        w_day_d = r_day + 6'd1;
                        w_doy_d = r_doy + 9'd1;
                    end else if (r_month != 4'd12) begin
                        w_day_d   = 6'd1;
                        w_month_d = r_month + 4'd1;
                        w_doy_d   = r_doy + 9'd1;
                    end else begin
                        w_day_d   = 6'd1;
                        w_month_d = 4'd1;
                        w_doy_d   = 9'd1;
                        if (r_year == '1) begin
                            // Year 0 is divisible by 400, hence leap.
                            w_year_d = '0;
                            w_leap_d = 1'b1;
                            w_wrap_d = 1'b1;
                        end else begin
                            w_year_d = r_year + YearOne;
                            w_leap_d = f_leap(r_year + YearOne);
                        end
                    end
                end
            end

            StCheck: begin
                if (!w_ld_ok) begin
                    w_err_d   = 1'b1;
                    w_state_d = StIdle;
                end else begin
                    w_ld_leap_d = w_ld_leap;
                    w_ld_doy_d  = w_ld_doy;
                    w_state_d   = StCommit;
                end
            end

            StCommit: begin
                w_day_d   = r_ld_day;
                w_month_d = r_ld_month;
                w_year_d  = r_ld_year;
                w_doy_d   = r_ld_doy;
                w_leap_d  = r_ld_leap;
`ifdef DAY_OF_WEEK_EN
                w_dow_d   = r_ld_dow;
`endif
                w_state_d = StIdle;
            end

            default: w_state_d = StIdle;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_day      <= 6'd1;
            r_month    <= 4'd1;
            r_year     <= RstYearV;
            r_doy      <= 9'd1;
            r_leap     <= RstLeap;
            r_err      <= 1'b0;
            r_wrap     <= 1'b0;
            r_ld_day   <= 6'd0;
            r_ld_month <= 4'd0;
            r_ld_year  <= '0;
            r_ld_doy   <= 9'd0;
            r_ld_leap  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_day      <= w_day_d;
            r_month    <= w_month_d;
            r_year     <= w_year_d;
            r_doy      <= w_doy_d;
            r_leap     <= w_leap_d;
            r_err      <= w_err_d;
            r_wrap     <= w_wrap_d;
            r_ld_day   <= w_ld_day_d;
            r_ld_month <= w_ld_month_d;
            r_ld_year  <= w_ld_year_d;
            r_ld_doy   <= w_ld_doy_d;
            r_ld_leap  <= w_ld_leap_d;
        end
    end

`ifdef DAY_OF_WEEK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dow    <= RstDowV;
            r_ld_dow <= 3'd0;
        end else begin
            r_dow    <= w_dow_d;
            r_ld_dow <= w_ld_dow_d;
        end
    end

    assign dow_o = r_dow;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign load_ready_o  = (r_state == StIdle);
    assign load_err_o    = r_err;
    assign year_wrap_o   = r_wrap;
    assign day_o         = r_day;
    assign month_o       = r_month;
    assign year_o        = r_year;
    assign day_of_year_o = r_doy;
    assign leap_o        = r_leap;

endmodule

// File: tb/tb_calendar_date_counter.sv
// -----------------------------------------------------------------------------
// tb_calendar_date_counter
//
// Scoreboard bench: each stimulus updates a small calendar model. The model's
// expected output state is queued and compared once the DUT has responded.
// -----------------------------------------------------------------------------
module tb_calendar_date_counter;

    localparam int unsigned YEAR_W = 11;
    localparam int          YMOD   = 1 << YEAR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tick_i = 1'b0;
    logic              load_valid_i = 1'b0;
    logic              load_ready_o;
    logic [5:0]        load_day_i = '0;
    logic [3:0]        load_month_i = '0;
    logic [YEAR_W-1:0] load_year_i = '0;
    logic              load_err_o;
    logic [5:0]        day_o;
    logic [3:0]        month_o;
    logic [YEAR_W-1:0] year_o;
    logic [8:0]        day_of_year_o;
    logic              leap_o;
    logic              year_wrap_o;
`ifdef DAY_OF_WEEK_EN
    logic [2:0]        load_dow_i = 3'd3;
    logic [2:0]        dow_o;
    int                m_dow;
`endif

    calendar_date_counter #(
        .YEAR_W  (YEAR_W),
        .RST_YEAR(2000),
        .RST_DOW (6)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_i       (tick_i),
        .load_valid_i (load_valid_i),
        .load_ready_o (load_ready_o),
        .load_day_i   (load_day_i),
        .load_month_i (load_month_i),
        .load_year_i  (load_year_i),
        .load_err_o   (load_err_o),
        .day_o        (day_o),
        .month_o      (month_o),
        .year_o       (year_o),
        .day_of_year_o(day_of_year_o),
        .leap_o       (leap_o),
`ifdef DAY_OF_WEEK_EN
        .load_dow_i   (load_dow_i),
        .dow_o        (dow_o),
`endif
        .year_wrap_o  (year_wrap_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int day;
        int month;
        int year;
        int doy;
        int leap;
        int wrap;
        int err;
        int dow;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_day, m_month, m_year;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int f_leap(input int y);
        return ((y % 400) == 0) || (((y % 4) == 0) && ((y % 100) != 0));
    endfunction

    function automatic int f_mlen(input int m, input int y);
        case (m)
            1, 3, 5, 7, 8, 10, 12: return 31;
            4, 6, 9, 11:           return 30;
            2:                     return 28 + f_leap(y);
            default:               return 0;
        endcase
    endfunction

    function automatic int f_doy(input int d, input int m, input int y);
        int s;
        s = d;
        for (int i = 1; i < m; i++) s += f_mlen(i, y);
        return s;
    endfunction

    task automatic model_reset();
        m_day   = 1;
        m_month = 1;
        m_year  = 2000;
`ifdef DAY_OF_WEEK_EN
        m_dow   = 6;
`endif
    endtask

    task automatic model_tick(output int wrap);
        wrap = 0;
`ifdef DAY_OF_WEEK_EN
        m_dow = (m_dow + 1) % 7;
`endif
        if (m_day < f_mlen(m_month, m_year)) begin
            m_day++;
        end else begin
            m_day = 1;
            if (m_month == 12) begin
                m_month = 1;
                wrap    = (m_year == YMOD - 1);
                m_year  = (m_year + 1) % YMOD;
            end else begin
                m_month++;
            end
        end
    endtask

    task automatic push_exp(input int wrap, input int err);
        exp_t e;
        e.day   = m_day;
        e.month = m_month;
        e.year  = m_year;
        e.doy   = f_doy(m_day, m_month, m_year);
        e.leap  = f_leap(m_year);
        e.wrap  = wrap;
        e.err   = err;
`ifdef DAY_OF_WEEK_EN
        e.dow   = m_dow;
`else
        e.dow   = 0;
`endif
        sb_q.push_back(e);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        check_eq({tag, "_day"},   32'(day_o),         32'(e.day));
        check_eq({tag, "_month"}, 32'(month_o),       32'(e.month));
        check_eq({tag, "_year"},  32'(year_o),        32'(e.year));
        check_eq({tag, "_doy"},   32'(day_of_year_o), 32'(e.doy));
        check_eq({tag, "_leap"},  32'(leap_o),        32'(e.leap));
        check_eq({tag, "_wrap"},  32'(year_wrap_o),   32'(e.wrap));
        check_eq({tag, "_err"},   32'(load_err_o),    32'(e.err));
`ifdef DAY_OF_WEEK_EN
        check_eq({tag, "_dow"},   32'(dow_o),         32'(e.dow));
`endif
    endtask

    task automatic do_tick(input string tag);
        int w;
        @(negedge clk);
        tick_i = 1'b1;
        model_tick(w);
        push_exp(w, 0);
        @(negedge clk);
        tick_i = 1'b0;
        compare_out(tag);
    endtask

    // tick_same: tick asserted together with load_valid_i.
    // tick_check: tick asserted while the block is in CHECK.
    task automatic do_load(input string tag, input int d, input int m, input int y,
                           input bit tick_same, input bit tick_check);
        int ok;
        @(negedge clk);
        check_eq({tag, "_rdy_idle"}, 32'(load_ready_o), 32'd1);
        load_valid_i = 1'b1;
        load_day_i   = 6'(d);
        load_month_i = 4'(m);
        load_year_i  = YEAR_W'(y);
        tick_i       = tick_same;
        ok = (m >= 1) && (m <= 12) && (d >= 1) && (d <= f_mlen(m, y));
        if (ok != 0) begin
            m_day   = d;
            m_month = m;
            m_year  = y;
`ifdef DAY_OF_WEEK_EN
            m_dow   = int'(load_dow_i);
`endif
        end
        push_exp(0, 0);
        @(negedge clk);
        load_valid_i = 1'b0;
        tick_i       = tick_check;
        check_eq({tag, "_rdy_busy"}, 32'(load_ready_o), 32'd0);
        @(negedge clk);
        tick_i = 1'b0;
        check_eq({tag, "_err_pulse"}, 32'(load_err_o), 32'(ok == 0));
        @(negedge clk);
        compare_out(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        push_exp(0, 0);
        compare_out("rst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_rdy", 32'(load_ready_o), 32'd1);
        push_exp(0, 0);
        compare_out("rst");

        do_tick("tick_first");

        do_load("ld_2000_0228", 28, 2, 2000, 1'b0, 1'b0);
        do_tick("tick_0229");
        do_tick("tick_0301");

        do_load("ld_1900_0228", 28, 2, 1900, 1'b0, 1'b0);
        do_tick("tick_1900_0301");

        do_load("ld_2023_1231", 31, 12, 2023, 1'b0, 1'b0);
        do_tick("tick_2024_0101");

        do_load("ld_bad_0229", 29, 2, 2023, 1'b0, 1'b0);
        do_load("ld_bad_m13", 1, 13, 2023, 1'b0, 1'b0);
        do_load("ld_bad_m0", 1, 0, 2023, 1'b0, 1'b0);
        do_load("ld_bad_d0", 0, 5, 2023, 1'b0, 1'b0);
        do_load("ld_bad_0431", 31, 4, 2023, 1'b0, 1'b0);

        do_load("ld_2047_1231", 31, 12, 2047, 1'b0, 1'b0);
        do_tick("tick_wrap");
        do_tick("tick_after_wrap");

        do_load("ld_tick_in_check", 15, 6, 2010, 1'b0, 1'b1);
        do_load("ld_tick_same", 30, 4, 2011, 1'b1, 1'b0);
        do_tick("tick_0501");

        do_load("ld_2024_1230", 30, 12, 2024, 1'b0, 1'b0);
        do_tick("tick_2024_1231");
        do_tick("tick_2025_0101");

        do_load("ld_run_start", 1, 1, 2023, 1'b0, 1'b0);
        for (int i = 0; i < 800; i++) do_tick("run");

        // Reset while a load sits in CHECK must discard it immediately.
        @(negedge clk);
        load_valid_i = 1'b1;
        load_day_i   = 6'd5;
        load_month_i = 4'd5;
        load_year_i  = YEAR_W'(2030);
        @(negedge clk);
        load_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        push_exp(0, 0);
        compare_out("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_exp(0, 0);
        compare_out("rst_after");
        @(negedge clk);
        check_eq("rst_after_rdy", 32'(load_ready_o), 32'd1);
        push_exp(0, 0);
        compare_out("rst_after2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
